// File: rtl/mandelbrot_iter_if.sv
// Point-in / result-out handshake bundle for the Mandelbrot iteration engine.
// valid/ready: a transfer happens on a rising edge where both valid and ready are 1; the sender holds its payload stable while valid is 1 and ready is 0.
interface mandelbrot_iter_if #(
  parameter int WIDTH  = 8,
  parameter int ITER_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_cr;
  logic [WIDTH-1:0]  in_ci;
  logic [ITER_W-1:0] in_max_iter;
  logic              out_valid;
  logic              out_ready;
  logic [ITER_W-1:0] out_count;
  logic              out_escaped;

  modport master (
    output in_valid, in_cr, in_ci, in_max_iter, out_ready,
    input  in_ready, out_valid, out_count, out_escaped
  );

  modport slave (
    input  in_valid, in_cr, in_ci, in_max_iter, out_ready,
    output in_ready, out_valid, out_count, out_escaped
  );
endinterface

// File: rtl/mandelbrot_iter.sv
// Iterates z <= z^2 + c with an external step ALU until escape, overflow or the
// iteration limit, then holds the count until the consumer takes it.
module mandelbrot_iter #(
  parameter int WIDTH  = 8,
  parameter int ITER_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  mandelbrot_iter_if.slave  bus,
  output logic [WIDTH-1:0]  alu_cr,
  output logic [WIDTH-1:0]  alu_ci,
  output logic [WIDTH-1:0]  alu_zr,
  output logic [WIDTH-1:0]  alu_zi,
  input  logic [WIDTH-1:0]  alu_zr_next,
  input  logic [WIDTH-1:0]  alu_zi_next,
  input  logic              alu_size,
  input  logic              alu_overflow,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ITER_W:0] ONE = {{ITER_W{1'b0}}, 1'b1};

  state_t            state;
  logic [ITER_W-1:0] max_iter;
  logic [ITER_W-1:0] iter;
  logic [ITER_W:0]   iter_inc;

  // One extra bit so the limit compare cannot alias when iter is all ones.
  assign iter_inc  = {1'b0, iter} + ONE;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      alu_cr          <= '0;
      alu_ci          <= '0;
      alu_zr          <= '0;
      alu_zi          <= '0;
      max_iter        <= '0;
      iter            <= '0;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.out_count   <= '0;
      bus.out_escaped <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            alu_cr       <= bus.in_cr;
            alu_ci       <= bus.in_ci;
            max_iter     <= bus.in_max_iter;
            alu_zr       <= '0;
            alu_zi       <= '0;
            iter         <= '0;
            bus.in_ready <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          if (max_iter == '0) begin
            state           <= DONE;
            bus.out_valid   <= 1'b1;
            bus.out_count   <= '0;
            bus.out_escaped <= 1'b0;
          end else if (alu_size || alu_overflow) begin
            state           <= DONE;
            bus.out_valid   <= 1'b1;
            bus.out_count   <= iter;
            bus.out_escaped <= 1'b1;
          end else if (iter_inc == {1'b0, max_iter}) begin
            state           <= DONE;
            bus.out_valid   <= 1'b1;
            bus.out_count   <= max_iter;
            bus.out_escaped <= 1'b0;
          end else begin
            alu_zr <= alu_zr_next;
            alu_zi <= alu_zi_next;
            iter   <= iter_inc[ITER_W-1:0];
          end
        end
        DONE: begin
          // in_ready rises with the handshake, so the next point waits one edge.
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mandelbrot_iter.sv
// Bench for mandelbrot_iter: fixed-point step ALU model, directed corner cases
// and random points checked against an arithmetic reference of the iteration.
module tb_mandelbrot_iter;
  localparam int W  = 8;
  localparam int IW = 6;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mandelbrot_iter_if #(.WIDTH(W), .ITER_W(IW)) bus();

  logic [W-1:0] alu_cr, alu_ci, alu_zr, alu_zi;
  logic [W-1:0] alu_zr_next, alu_zi_next;
  logic         alu_size, alu_overflow;
  logic [1:0]   state_dbg;

  mandelbrot_iter #(.WIDTH(W), .ITER_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .alu_cr       (alu_cr),
    .alu_ci       (alu_ci),
    .alu_zr       (alu_zr),
    .alu_zi       (alu_zi),
    .alu_zr_next  (alu_zr_next),
    .alu_zi_next  (alu_zi_next),
    .alu_size     (alu_size),
    .alu_overflow (alu_overflow),
    .state_dbg    (state_dbg)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  // fixed-point arithmetic, 1.0 = 64
  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction
  function automatic int next_r(input int zr, input int zi, input int cr);
    return ((zr * zr - zi * zi) >>> 6) + cr;
  endfunction
  function automatic int next_i(input int zr, input int zi, input int ci);
    return ((2 * zr * zi) >>> 6) + ci;
  endfunction
  function automatic bit too_big(input int zr, input int zi);
    return (zr * zr + zi * zi) > 4 * 4096;
  endfunction
  function automatic bit out_of_range(input int v);
    return (v > 127) || (v < -128);
  endfunction

  // external step ALU
  int nr, ni;
  always_comb begin
    nr = next_r(sx(alu_zr), sx(alu_zi), sx(alu_cr));
    ni = next_i(sx(alu_zr), sx(alu_zi), sx(alu_ci));
  end
  assign alu_zr_next  = nr[W-1:0];
  assign alu_zi_next  = ni[W-1:0];
  assign alu_size     = too_big(sx(alu_zr), sx(alu_zi));
  assign alu_overflow = out_of_range(nr) || out_of_range(ni);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // reference: expected result, RUN cycle count and zr seen in each RUN cycle
  task automatic model(input int cr, input int ci, input int mx,
                       output int cnt, output int esc, output int cyc);
    int zr, zi, tr, ti;
    exp_q.delete();
    zr = 0; zi = 0; cnt = 0; esc = 0; cyc = 1;
    if (mx == 0) begin
      exp_q.push_back('0);
      return;
    end
    for (int it = 0; it < mx; it++) begin
      exp_q.push_back(zr[W-1:0]);
      tr  = next_r(zr, zi, cr);
      ti  = next_i(zr, zi, ci);
      cyc = it + 1;
      if (too_big(zr, zi) || out_of_range(tr) || out_of_range(ti)) begin
        cnt = it; esc = 1;
        return;
      end
      if (it + 1 == mx) begin
        cnt = mx; esc = 0;
        return;
      end
      zr = tr; zi = ti;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    check("in_ready_idle", bus.in_ready, 1);
  endtask

  task automatic wait_result();
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    check("result_timeout", bus.out_valid, 1);
  endtask

  // driver: offer one point, follow the run, hold backpressure, take result
  task automatic run_point(input int cr, input int ci, input int mx, input int hold);
    int cnt, esc, cyc, cycles;
    model(cr, ci, mx, cnt, esc, cyc);
    wait_idle();
    bus.in_valid    = 1'b1;
    bus.in_cr       = cr[W-1:0];
    bus.in_ci       = ci[W-1:0];
    bus.in_max_iter = mx[IW-1:0];
    tick();
    bus.in_valid = 1'b0;
    check("in_ready_run", bus.in_ready, 0);
    check("alu_cr", alu_cr, cr[W-1:0]);
    check("alu_ci", alu_ci, ci[W-1:0]);
    cycles = 0;
    while (!bus.out_valid && cycles < 100) begin
      if (exp_q.size() > 0) check("alu_zr", alu_zr, exp_q.pop_front());
      cycles++;
      tick();
    end
    check("out_valid", bus.out_valid, 1);
    check("run_cycles", cycles, cyc);
    check("out_count", bus.out_count, cnt);
    check("out_escaped", bus.out_escaped, esc);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", bus.out_valid, 1);
      check("hold_count", bus.out_count, cnt);
      check("hold_escaped", bus.out_escaped, esc);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("valid_drop", bus.out_valid, 0);
    check("in_ready_back", bus.in_ready, 1);
  endtask

  initial begin
    int seen;
    bus.in_valid    = 1'b0;
    bus.in_cr       = '0;
    bus.in_ci       = '0;
    bus.in_max_iter = '0;
    bus.out_ready   = 1'b0;
    rst = 1'b1;
    #3;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_count", bus.out_count, 0);
    check("rst_state", state_dbg, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_alu_zr", alu_zr, 0);

    // escape, bounded orbit, zero and max limits, backpressure
    run_point(96, 0, 20, 0);
    run_point(-64, 0, 20, 0);
    run_point(0, 0, 0, 0);
    run_point(0, 0, 63, 0);
    run_point(96, 0, 20, 10);

    // reset in iteration 5 drops the point in flight
    wait_idle();
    bus.in_valid = 1'b1; bus.in_cr = 8'd0; bus.in_ci = 8'd0; bus.in_max_iter = 6'd40;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_state", state_dbg, 0);
    check("mid_rst_count", bus.out_count, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("no_stale_result", seen, 0);
    run_point(32, 16, 10, 1);

    // back-to-back with in_valid held high
    wait_idle();
    bus.in_valid = 1'b1; bus.in_cr = 8'd96; bus.in_ci = 8'd0; bus.in_max_iter = 6'd20;
    tick();
    wait_result();
    check("b2b_first_count", bus.out_count, 1);
    bus.in_cr = 8'hC0; bus.in_max_iter = 6'd3;
    bus.out_ready = 1'b1;
    tick();
    check("b2b_idle", state_dbg, 0);
    check("b2b_not_taken", alu_cr, 96);
    check("b2b_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b_taken_ready", bus.in_ready, 0);
    check("b2b_taken_cr", alu_cr, 8'hC0);
    wait_result();
    check("b2b_second_count", bus.out_count, 3);
    check("b2b_second_esc", bus.out_escaped, 0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // random points
    for (int r = 0; r < 25; r++) begin
      run_point(int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100,
                int'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
